fifo_ctrl: RTL
==============

# fifo_ctrl

Pointer and flag controller for the FIFO memory path. It accepts write and read requests from the producer and consumer, gates them against full and empty, and drives the storage array's write and read enables and pointers. It keeps occupancy and threshold status, plus sticky overflow and underflow error flags. It sits directly upstream of the memory array: its enable and pointer outputs connect port-for-port to the array's enable and pointer inputs.

## Interface
- OSTD_NUM, 8, FIFO depth in entries; legal range is 1 and up, and it need not be a power of 2
- THRESHOLD_VALUE, OSTD_NUM/2, low-water mark for below_threshold
- PTR_SIZE, (OSTD_NUM > 1) ? $clog2(OSTD_NUM) : 1, internal pointer index width
---
- clk_in  in  1  clock; one clock domain, all logic on its rising edge
- areset_b  in  1  reset; asynchronous, active-low
- wr_req  in  1  producer write request for this cycle
- rd_req  in  1  consumer read request for this cycle
- err_clr  in  1  synchronous clear of both error flags
- fifo_wenable  out  1  write enable to the array
- fifo_renable  out  1  read enable to the array
- write_ptr  out  OSTD_NUM  write index, zero-extended from PTR_SIZE
- read_ptr  out  OSTD_NUM  read index, zero-extended from PTR_SIZE
- fill_count  out  PTR_SIZE+1  current occupancy, 0..OSTD_NUM
- fifo_full  out  1  fill_count == OSTD_NUM
- fifo_empty  out  1  fill_count == 0
- below_threshold  out  1  fill_count < THRESHOLD_VALUE
- overflow_err  out  1  sticky; set when a write was rejected
- underflow_err  out  1  sticky; set when a read was rejected

## Operation
- Registered state: wr_idx, rd_idx, count, ovf, udf. Every other output is decoded combinationally from these registers and the request inputs.
- Write acceptance: fifo_wenable = wr_req & ~fifo_full.
- Read acceptance: fifo_renable = rd_req & ~fifo_empty.
- Full and empty are evaluated on the state held at the start of the cycle.
  - When full, a write is rejected even if a read is accepted in the same cycle.
  - When empty, a read is rejected even if a write is accepted in the same cycle. There is no fall-through path.
- Accepted write: wr_idx advances by 1. When wr_idx is OSTD_NUM-1 it wraps to 0. This is an explicit compare, not modulo-2^PTR_SIZE.
- Accepted read: rd_idx advances by 1 with the same wrap rule.
- count update:
  - +1 on a write-only accept
  - −1 on a read-only accept
  - unchanged when both are accepted or neither is
  - count never leaves the range 0..OSTD_NUM
- write_ptr and read_ptr carry the raw indices. Bits above PTR_SIZE are always 0.
- Error flags:
  - ovf is set when wr_req & fifo_full.
  - udf is set when rd_req & fifo_empty.
  - Both hold until err_clr.
  - If err_clr and a new error condition occur in the same cycle, set wins and the flag stays 1.
- Rejected requests never change the pointers or count.

## Timing
- Reset (areset_b low, applied asynchronously):
  - wr_idx = 0, rd_idx = 0, count = 0, ovf = 0, udf = 0
  - fifo_empty = 1, fifo_full = 0
  - below_threshold = (THRESHOLD_VALUE > 0)
  - fifo_wenable and fifo_renable are forced to 0 while areset_b is low, regardless of the requests
- Write path: fifo_wenable and write_ptr are valid in the request cycle. The array captures data at that cycle's clock edge. Pointer, count and flags update at the same edge.
- Read path: fifo_renable and read_ptr are valid in the request cycle. The array's data_out is valid combinationally in that same cycle, so read latency is 0 cycles. read_ptr advances at the edge that ends the cycle.
- Write-to-read: data written in cycle N is readable at the earliest in cycle N+1.
- Flags reflect post-edge state one cycle after the accepting edge. They never reflect same-cycle requests.
- Reset asserted mid-burst: all state returns to reset values immediately. The first request is honoured on the first rising edge after areset_b deasserts.

## Test plan
- Fill and drain (OSTD_NUM=8): issue 8 back-to-back writes.
  - After the 8th write: fill_count=8, full=1, write_ptr=0 (wrapped).
  - Then issue 8 reads: read_ptr steps 0..7 then returns to 0, empty=1.
- Overflow: from full, assert wr_req for 1 cycle.
  - Required: fifo_wenable=0, count stays 8, overflow_err=1 and holds.
  - err_clr for 1 cycle → overflow_err=0 on the next cycle.
- Underflow: after reset, assert rd_req.
  - Required: fifo_renable=0, underflow_err=1, read_ptr=0.
  - Same-cycle err_clr plus rd_req → underflow_err stays 1.
- Simultaneous requests:
  - At count=3, wr+rd accepted → count stays 3, both pointers advance.
  - At count=8, wr+rd → only the read is accepted, count=7.
  - At count=0, wr+rd → only the write is accepted, count=1.
- Threshold (THRESHOLD_VALUE=4): below_threshold=1 at counts 0..3 and 0 at count 4. It returns to 1 after one read from count 4.
- Non-power-of-2 depth and reset mid-operation:
  - OSTD_NUM=5: write_ptr sequence 0,1,2,3,4,0, with upper bits of write_ptr 0.
  - At count=3, drop areset_b between edges → all outputs take reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and error-flag controller for a single-clock FIFO storage array.
// Requests are gated against full/empty held at the start of the cycle; there is no fall-through.
module fifo_ctrl #(
    parameter int unsigned OSTD_NUM        = 8,
    parameter int unsigned THRESHOLD_VALUE = OSTD_NUM / 2,
    parameter int unsigned PTR_SIZE        = (OSTD_NUM > 1) ? $clog2(OSTD_NUM) : 1
) (
    input  logic                clk_in,
    input  logic                areset_b,
    input  logic                wr_req,
    input  logic                rd_req,
    input  logic                err_clr,
    output logic                fifo_wenable,
    output logic                fifo_renable,
    output logic [OSTD_NUM-1:0] write_ptr,
    output logic [OSTD_NUM-1:0] read_ptr,
    output logic [PTR_SIZE:0]   fill_count,
    output logic                fifo_full,
    output logic                fifo_empty,
    output logic                below_threshold,
    output logic                overflow_err,
    output logic                underflow_err
);

    localparam logic [PTR_SIZE-1:0] LastIdx = PTR_SIZE'(OSTD_NUM - 1);
    localparam logic [PTR_SIZE:0]   Depth   = (PTR_SIZE + 1)'(OSTD_NUM);

    logic [PTR_SIZE-1:0] wr_idx_q, wr_idx_d;
    logic [PTR_SIZE-1:0] rd_idx_q, rd_idx_d;
    logic [PTR_SIZE:0]   count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

    assign fifo_full       = (count_q == Depth);
    assign fifo_empty      = (count_q == '0);
    assign below_threshold = (32'(count_q) < THRESHOLD_VALUE);
    assign fill_count      = count_q;
    assign overflow_err    = ovf_q;
    assign underflow_err   = udf_q;

    // Enables are masked by reset so the array never sees a stray write while held in reset.
    assign fifo_wenable = areset_b & wr_req & ~fifo_full;
    assign fifo_renable = areset_b & rd_req & ~fifo_empty;

    always_comb begin
        write_ptr                 = '0;
        read_ptr                  = '0;
        write_ptr[PTR_SIZE-1:0]   = wr_idx_q;
        read_ptr[PTR_SIZE-1:0]    = rd_idx_q;
    end

    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;

        // Explicit wrap keeps non-power-of-2 depths correct.
        if (fifo_wenable) begin
            wr_idx_d = (wr_idx_q == LastIdx) ? '0 : wr_idx_q + PTR_SIZE'(1);
        end
        if (fifo_renable) begin
            rd_idx_d = (rd_idx_q == LastIdx) ? '0 : rd_idx_q + PTR_SIZE'(1);
        end

        case ({fifo_wenable, fifo_renable})
            2'b10:   count_d = count_q + (PTR_SIZE + 1)'(1);
            2'b01:   count_d = count_q - (PTR_SIZE + 1)'(1);
            default: count_d = count_q;
        endcase

        // A new error in the clearing cycle takes priority over the clear.
        ovf_d = (wr_req & fifo_full) | (ovf_q & ~err_clr);
        udf_d = (rd_req & fifo_empty) | (udf_q & ~err_clr);
    end

    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

endmodule
